hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  pipeline clock, rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: id_rs1, id_rs2  in  5 each  source registers of the ID-stage instruction.
REQ-004 SHALL have ports: id_use_rs1, id_use_rs2  in  1 each  ID instruction reads that source.
REQ-005 SHALL have ports: ex_wreg  in  5 / ex_regwrite  in  1 / ex_is_load  in  1  destination, write enable and load flag of the ID/EX-register instruction.
REQ-006 SHALL have ports: mem_wreg  in  5 / mem_regwrite  in  1  destination and write enable of the EX/MEM-register instruction.
REQ-007 SHALL have ports: wb_wreg  in  5 / wb_regwrite  in  1  destination and write enable of the MEM/WB-register instruction.
REQ-008 SHALL have ports: branch_taken  in  1  resolved taken branch or jump in MEM.
REQ-009 SHALL have ports: dmem_busy  in  1  data memory not ready.
REQ-010 SHALL have ports: pc_keep, ifid_keep, ifid_nop  out  1 each  PC hold; IF/ID hold; IF/ID bubble.
REQ-011 SHALL have ports: idex_keep, idex_nop, exmem_keep  out  1 each  execute-stage keep/nop inputs; EX/MEM hold.
REQ-012 SHALL have ports: fwd_ex_pyc, fwd_mem_pyc, fwd_wb_pyc, fwd_load_pyc  out  2 each  forwarding selects, bit1=rs1, bit0=rs2.
REQ-013 SHALL have ports: state  out  2  FSM state: RUN=0, LOAD_STALL=1, MEM_WAIT=2, FLUSH=3.

Function
REQ-014 Hazard priority SHALL be: branch_taken > dmem_busy > load-use > forwarding.
REQ-015 Register x0 SHALL never match for forwarding or stall purposes.
REQ-016 Load-use hazard (LU) SHALL be: ex_is_load & ex_regwrite & ex_wreg!=0 & ((id_use_rs1 & id_rs1==ex_wreg) | (id_use_rs2 & id_rs2==ex_wreg)).
REQ-017 Keep/nop outputs SHALL be combinational from state and inputs; forwarding selects SHALL be registered.
REQ-018 RUN: with no hazard, all keep/nop outputs SHALL be 0.
REQ-019 RUN: on LU, pc_keep=1, ifid_keep=1 and idex_nop=1 for exactly that cycle; next state LOAD_STALL.
REQ-020 LOAD_STALL: no keep or nop asserted; fwd_load_pyc SHALL carry the operand bits that matched in REQ-016 (latched at the LU edge); next state RUN, or MEM_WAIT if dmem_busy.
REQ-021 dmem_busy=1 in any state without branch_taken: pc_keep, ifid_keep, idex_keep and exmem_keep SHALL be 1 and all nops 0; state SHALL go or stay MEM_WAIT.
REQ-022 MEM_WAIT SHALL exit to RUN on the first edge with dmem_busy=0; registered forwarding selects SHALL hold throughout.
REQ-023 branch_taken=1: ifid_nop=1 and idex_nop=1 for that cycle, all keeps 0, regardless of LU or dmem_busy; next state FLUSH.
REQ-024 FLUSH: ifid_nop=1 for one cycle (wrong-path fetch in flight); next state RUN; LU in this cycle SHALL be ignored.
REQ-025 Forwarding selects SHALL update each edge where idex_keep=0, computed from the ID instruction for its EX cycle.
REQ-026 Forwarding source of the ID instruction: match on ex_wreg (non-load, regwrite) -> fwd_ex_pyc; else match on mem_wreg/mem_regwrite -> fwd_mem_pyc; else match on wb_wreg/wb_regwrite -> fwd_wb_pyc.
REQ-027 Per operand bit, at most one of the four select vectors SHALL be 1.
REQ-028 Forwarding selects SHALL be cleared to 0 on any edge where idex_nop=1, except fwd_load_pyc per REQ-020.
REQ-029 FSM SHALL have no other reachable state; an illegal state SHALL recover to RUN on the next edge.

Reset
REQ-030 On rst=0, state SHALL be RUN immediately, independent of clk.
REQ-031 On rst=0, all four forwarding selects and the latched LU operand bits SHALL be 0 immediately.
REQ-032 With rst=0, all keep/nop outputs SHALL be 0.
REQ-033 Reset asserted mid-stall or mid-flush SHALL abort it; the first edge after release SHALL evaluate from RUN.

Verification
REQ-034 Load-use: ex_is_load=1, ex_wreg=5, id_rs1=5, id_use_rs1=1 -> cycle 0: pc_keep=ifid_keep=idex_nop=1; cycle 1: state=1, fwd_load_pyc=2'b10; cycle 2: RUN.
REQ-035 Forward priority: ex_wreg=mem_wreg=wb_wreg=7, all regwrite, id_rs2=7 -> next edge fwd_ex_pyc=2'b01, fwd_mem_pyc=fwd_wb_pyc=0.
REQ-036 x0: ex_wreg=0, ex_is_load=1, id_rs1=0 -> no stall, all selects 0.
REQ-037 Memory wait: dmem_busy high 3 cycles -> all keeps 1 for 3 cycles, state=2, selects unchanged; RUN on the following edge.
REQ-038 Branch vs load-use in the same cycle -> ifid_nop=idex_nop=1, pc_keep=0; FLUSH for one cycle with ifid_nop=1; then RUN.
REQ-039 Reset during LOAD_STALL -> state=0 and fwd_load_pyc=0 without a clock edge.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, memory-wait hold, branch flush and
// registered operand-forwarding selects for a 5-stage in-order pipeline.
module hazard_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] ex_wreg,
    input  logic       ex_regwrite,
    input  logic       ex_is_load,
    input  logic [4:0] mem_wreg,
    input  logic       mem_regwrite,
    input  logic [4:0] wb_wreg,
    input  logic       wb_regwrite,
    input  logic       branch_taken,
    input  logic       dmem_busy,
    output logic       pc_keep,
    output logic       ifid_keep,
    output logic       ifid_nop,
    output logic       idex_keep,
    output logic       idex_nop,
    output logic       exmem_keep,
    output logic [1:0] fwd_ex_pyc,
    output logic [1:0] fwd_mem_pyc,
    output logic [1:0] fwd_wb_pyc,
    output logic [1:0] fwd_load_pyc,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        StRun       = 2'd0,
        StLoadStall = 2'd1,
        StMemWait   = 2'd2,
        StFlush     = 2'd3
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] fwd_ex_q, fwd_mem_q, fwd_wb_q, fwd_load_q;

    logic [1:0] ex_hit, mem_hit, wb_hit;
    logic [1:0] lu_bits, ex_fwd, mem_fwd, wb_fwd;
    logic       lu, lu_stall;

    // Bit 1 = rs1, bit 0 = rs2; x0 never matches.
    assign ex_hit  = {id_use_rs1 & (id_rs1 == ex_wreg), id_use_rs2 & (id_rs2 == ex_wreg)}
                     & {2{ex_wreg != 5'd0}};
    assign mem_hit = {id_use_rs1 & (id_rs1 == mem_wreg), id_use_rs2 & (id_rs2 == mem_wreg)}
                     & {2{mem_regwrite & (mem_wreg != 5'd0)}};
    assign wb_hit  = {id_use_rs1 & (id_rs1 == wb_wreg), id_use_rs2 & (id_rs2 == wb_wreg)}
                     & {2{wb_regwrite & (wb_wreg != 5'd0)}};

    assign lu_bits = ex_hit & {2{ex_is_load & ex_regwrite}};
    assign lu      = |lu_bits;
    assign ex_fwd  = ex_hit & {2{ex_regwrite & ~ex_is_load}};
    assign mem_fwd = mem_hit & ~ex_fwd;
    assign wb_fwd  = wb_hit & ~ex_fwd & ~mem_hit;

    always_comb begin
        pc_keep    = 1'b0;
        ifid_keep  = 1'b0;
        ifid_nop   = 1'b0;
        idex_keep  = 1'b0;
        idex_nop   = 1'b0;
        exmem_keep = 1'b0;
        lu_stall   = 1'b0;
        state_d    = StRun;
        if (!rst) begin
            state_d = StRun;
        end else if (branch_taken) begin
            ifid_nop = 1'b1;
            idex_nop = 1'b1;
            state_d  = StFlush;
        end else if (dmem_busy) begin
            pc_keep    = 1'b1;
            ifid_keep  = 1'b1;
            idex_keep  = 1'b1;
            exmem_keep = 1'b1;
            state_d    = StMemWait;
        end else begin
            case (state_q)
                StRun: begin
                    if (lu) begin
                        pc_keep   = 1'b1;
                        ifid_keep = 1'b1;
                        idex_nop  = 1'b1;
                        lu_stall  = 1'b1;
                        state_d   = StLoadStall;
                    end
                end
                StLoadStall: state_d = StRun;
                StMemWait:   state_d = StRun;
                // Wrong-path fetch still in flight; any load-use match is spurious.
                StFlush: begin
                    ifid_nop = 1'b1;
                    state_d  = StRun;
                end
                default:     state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StRun;
            fwd_ex_q   <= 2'b00;
            fwd_mem_q  <= 2'b00;
            fwd_wb_q   <= 2'b00;
            fwd_load_q <= 2'b00;
        end else begin
            state_q <= state_d;
            if (idex_nop) begin
                fwd_ex_q   <= 2'b00;
                fwd_mem_q  <= 2'b00;
                fwd_wb_q   <= 2'b00;
                fwd_load_q <= lu_stall ? lu_bits : 2'b00;
            end else if (!idex_keep) begin
                fwd_ex_q   <= ex_fwd;
                fwd_mem_q  <= mem_fwd;
                fwd_wb_q   <= wb_fwd;
                fwd_load_q <= 2'b00;
            end
        end
    end

    assign state        = state_q;
    assign fwd_ex_pyc   = fwd_ex_q;
    assign fwd_mem_pyc  = fwd_mem_q;
    assign fwd_wb_pyc   = fwd_wb_q;
    assign fwd_load_pyc = fwd_load_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, forwarding priority, x0, memory wait,
// branch flush and asynchronous reset.
module tb_hazard_ctrl;

    logic       clk, rst;
    logic [4:0] id_rs1, id_rs2, ex_wreg, mem_wreg, wb_wreg;
    logic       id_use_rs1, id_use_rs2, ex_regwrite, ex_is_load;
    logic       mem_regwrite, wb_regwrite, branch_taken, dmem_busy;
    logic       pc_keep, ifid_keep, ifid_nop, idex_keep, idex_nop, exmem_keep;
    logic [1:0] fwd_ex_pyc, fwd_mem_pyc, fwd_wb_pyc, fwd_load_pyc, state;

    int tests_run = 0;
    int tests_failed = 0;

    hazard_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .ex_wreg      (ex_wreg),
        .ex_regwrite  (ex_regwrite),
        .ex_is_load   (ex_is_load),
        .mem_wreg     (mem_wreg),
        .mem_regwrite (mem_regwrite),
        .wb_wreg      (wb_wreg),
        .wb_regwrite  (wb_regwrite),
        .branch_taken (branch_taken),
        .dmem_busy    (dmem_busy),
        .pc_keep      (pc_keep),
        .ifid_keep    (ifid_keep),
        .ifid_nop     (ifid_nop),
        .idex_keep    (idex_keep),
        .idex_nop     (idex_nop),
        .exmem_keep   (exmem_keep),
        .fwd_ex_pyc   (fwd_ex_pyc),
        .fwd_mem_pyc  (fwd_mem_pyc),
        .fwd_wb_pyc   (fwd_wb_pyc),
        .fwd_load_pyc (fwd_load_pyc),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {pc_keep, ifid_keep, ifid_nop, idex_keep, idex_nop, exmem_keep}
    function automatic logic [5:0] ctl();
        return {pc_keep, ifid_keep, ifid_nop, idex_keep, idex_nop, exmem_keep};
    endfunction

    // {ex, mem, wb, load}
    function automatic logic [7:0] fwd();
        return {fwd_ex_pyc, fwd_mem_pyc, fwd_wb_pyc, fwd_load_pyc};
    endfunction

    task automatic clear_inputs();
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_wreg = 0; ex_regwrite = 0; ex_is_load = 0;
        mem_wreg = 0; mem_regwrite = 0; wb_wreg = 0; wb_regwrite = 0;
        branch_taken = 0; dmem_busy = 0;
    endtask

    task automatic set_lu_r5();
        ex_is_load = 1; ex_regwrite = 1; ex_wreg = 5; id_rs1 = 5; id_use_rs1 = 1;
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b0;
        #2;
        chk("reset_state", state, 0);
        chk("reset_fwd", fwd(), 0);
        set_lu_r5();
        branch_taken = 1;
        #1;
        chk("reset_ctl_quiet", ctl(), 0);
        clear_inputs();
        rst = 1'b1;

        // Load-use on rs1.
        step();
        chk("idle_state", state, 0);
        set_lu_r5();
        #1;
        chk("lu_ctl", ctl(), 6'b110010);
        step();
        chk("lu_state_stall", state, 1);
        chk("lu_fwd_load", fwd(), 8'b00_00_00_10);
        clear_inputs();
        id_rs1 = 5; id_use_rs1 = 1; mem_wreg = 5; mem_regwrite = 1;
        #1;
        chk("stall_ctl_quiet", ctl(), 0);
        step();
        chk("lu_back_run", state, 0);
        chk("after_stall_fwd_mem", fwd(), 8'b00_10_00_00);

        // Forwarding priority on rs2.
        clear_inputs();
        ex_wreg = 7; mem_wreg = 7; wb_wreg = 7;
        ex_regwrite = 1; mem_regwrite = 1; wb_regwrite = 1;
        id_rs2 = 7; id_use_rs2 = 1;
        step();
        chk("prio_ex", fwd(), 8'b01_00_00_00);
        ex_regwrite = 0;
        step();
        chk("prio_mem", fwd(), 8'b00_01_00_00);
        mem_regwrite = 0;
        id_rs1 = 7; id_use_rs1 = 1;
        step();
        chk("prio_wb_both", fwd(), 8'b00_00_11_00);

        // x0 never matches.
        clear_inputs();
        ex_is_load = 1; ex_regwrite = 1; id_rs1 = 0; id_use_rs1 = 1;
        mem_regwrite = 1; wb_regwrite = 1;
        #1;
        chk("x0_no_stall", ctl(), 0);
        step();
        chk("x0_state", state, 0);
        chk("x0_fwd", fwd(), 0);

        // Memory wait: selects frozen while busy.
        clear_inputs();
        id_rs1 = 9; id_use_rs1 = 1; ex_wreg = 9; ex_regwrite = 1;
        step();
        chk("mw_pre_fwd", fwd(), 8'b10_00_00_00);
        dmem_busy = 1;
        ex_regwrite = 0; wb_wreg = 9; wb_regwrite = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("mw_ctl_%0d", i), ctl(), 6'b110101);
            step();
            chk($sformatf("mw_state_%0d", i), state, 2);
            chk($sformatf("mw_fwd_hold_%0d", i), fwd(), 8'b10_00_00_00);
        end
        dmem_busy = 0;
        #1;
        chk("mw_exit_ctl", ctl(), 0);
        step();
        chk("mw_exit_state", state, 0);
        chk("mw_exit_fwd", fwd(), 8'b00_00_10_00);

        // Branch beats load-use.
        clear_inputs();
        set_lu_r5();
        branch_taken = 1;
        #1;
        chk("br_ctl", ctl(), 6'b001010);
        step();
        chk("br_state_flush", state, 3);
        chk("br_fwd_clear", fwd(), 0);
        branch_taken = 0;
        #1;
        chk("flush_ctl", ctl(), 6'b001000);
        step();
        chk("flush_back_run", state, 0);

        // Asynchronous reset during LOAD_STALL.
        clear_inputs();
        step();
        set_lu_r5();
        step();
        chk("pre_rst_state", state, 1);
        chk("pre_rst_fwd_load", fwd_load_pyc, 2'b10);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_async_state", state, 0);
        chk("rst_async_fwd_load", fwd_load_pyc, 0);
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("post_rst_state", state, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
